lbus_arbiter: RTL

//  Sequences ownership of the card-internal local bus and the Zorro III bus between host slave

---
 rtl/lbus_pkg.sv | 18 +
 rtl/lbus_arbiter_if.sv | 29 ++
 rtl/lbus_arbiter_sync2.sv | 24 ++
 rtl/lbus_arbiter.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/lbus_pkg.sv
// rtl/lbus_pkg.sv - shared state encoding and default parameters for the local bus arbiter
package lbus_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SLAVE = 3'd1,
    ZREQ  = 3'd2,
    ZWAIT = 3'd3,
    OWN   = 3'd4,
    REL   = 3'd5,
    HOLD  = 3'd6
  } state_t;

  localparam int DEF_MAX_BEATS = 16;
  localparam int DEF_HOLDOFF   = 4;
  localparam int DEF_TIMEOUT   = 255;

endpackage

// File: rtl/lbus_arbiter_if.sv
// rtl/lbus_arbiter_if.sv - host/NCR/Zorro handshake signals seen by the local bus arbiter
interface lbus_arbiter_if;

  logic slave_req;
  logic slave_done;
  logic SBR_n;
  logic MASTER_n;
  logic EBG_n;
  logic FCS_n;
  logic DTACK_n;
  logic BERR_n;
  logic slave_gnt;
  logic SBG_n;
  logic EBR_n;
  logic mybus;
  logic dma_abort;
  logic dma_timeout;

  modport slave (
    input  slave_req, slave_done, SBR_n, MASTER_n, EBG_n, FCS_n, DTACK_n, BERR_n,
    output slave_gnt, SBG_n, EBR_n, mybus, dma_abort, dma_timeout
  );

  modport master (
    output slave_req, slave_done, SBR_n, MASTER_n, EBG_n, FCS_n, DTACK_n, BERR_n,
    input  slave_gnt, SBG_n, EBR_n, mybus, dma_abort, dma_timeout
  );

endinterface

// File: rtl/lbus_arbiter_sync2.sv
// rtl/lbus_arbiter_sync2.sv - two-flop synchroniser for active-low async inputs, resets to 1
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/lbus_arbiter.sv
// rtl/lbus_arbiter.sv - local/Zorro bus ownership between host slave cycles and NCR DMA
// Optional DMA watchdog enabled by defining WATCHDOG_EN.
module lbus_arbiter
  import lbus_pkg::*;
#(
  parameter int MAX_BEATS = DEF_MAX_BEATS,
  parameter int HOLDOFF   = DEF_HOLDOFF
`ifdef WATCHDOG_EN
  ,
  parameter int TIMEOUT   = DEF_TIMEOUT
`endif
) (
  input  logic           clk,
  input  logic           IORST_n,
  lbus_arbiter_if.slave  bus
);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_beat_cnt;
  logic [7:0] r_hold_cnt;
  logic       r_dtack_d;
  logic       r_dma_abort;

  logic w_sbr_n_s;
  logic w_ebg_n_s;
  logic w_sbr;
  logic w_ebg;
  logic w_bus_free;
  logic w_dtack_fall;
  logic w_cap;
  logic w_done;
  logic w_hold_exp;
  logic w_abort;

  sync2 u_sync_sbr (.clk(clk), .rst_n(IORST_n), .i_d(bus.SBR_n), .o_q(w_sbr_n_s));
  sync2 u_sync_ebg (.clk(clk), .rst_n(IORST_n), .i_d(bus.EBG_n), .o_q(w_ebg_n_s));

  assign w_sbr        = ~w_sbr_n_s;
  assign w_ebg        = ~w_ebg_n_s;
  assign w_bus_free   = w_ebg & bus.FCS_n & bus.DTACK_n;
  assign w_dtack_fall = r_dtack_d & ~bus.DTACK_n;
  // Cap only takes effect between NCR cycles so the in-flight transfer completes.
  assign w_cap        = (r_beat_cnt == 8'(MAX_BEATS)) & bus.MASTER_n;
  assign w_done       = ~w_sbr & bus.MASTER_n;
  assign w_hold_exp   = ({1'b0, r_hold_cnt} + 9'd1) >= 9'(HOLDOFF);

`ifdef WATCHDOG_EN
  logic [7:0] r_wd_cnt;
  logic       r_dma_timeout;
  logic       w_wd_hit;

  assign w_wd_hit = (r_wd_cnt == 8'(TIMEOUT));
  assign w_abort  = ~bus.BERR_n | w_wd_hit;

  always_ff @(posedge clk or negedge IORST_n) begin
    if (!IORST_n) begin
      r_wd_cnt      <= 8'd0;
      r_dma_timeout <= 1'b0;
    end else begin
      if (r_state != OWN || !bus.DTACK_n) begin
        r_wd_cnt <= 8'd0;
      end else if (!w_wd_hit) begin
        r_wd_cnt <= r_wd_cnt + 8'd1;
      end
      if (r_state == OWN && w_wd_hit) begin
        r_dma_timeout <= 1'b1;
      end
    end
  end

  assign bus.dma_timeout = r_dma_timeout;
`else
  assign w_abort         = ~bus.BERR_n;
  assign bus.dma_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge IORST_n) begin
    if (!IORST_n) begin
      r_state     <= IDLE;
      r_beat_cnt  <= 8'd0;
      r_hold_cnt  <= 8'd0;
      r_dtack_d   <= 1'b1;
      r_dma_abort <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_dtack_d   <= bus.DTACK_n;
      r_dma_abort <= (r_state == OWN) & w_abort;
      if (r_state != OWN) begin
        r_beat_cnt <= 8'd0;
      end else if (w_dtack_fall && r_beat_cnt != 8'(MAX_BEATS)) begin
        r_beat_cnt <= r_beat_cnt + 8'd1;
      end
      if (r_state == HOLD) begin
        r_hold_cnt <= r_hold_cnt + 8'd1;
      end else begin
        r_hold_cnt <= 8'd0;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (bus.slave_req)  w_state_nxt = SLAVE;
        else if (w_sbr)     w_state_nxt = ZREQ;
      end
      SLAVE: begin
        if (bus.slave_done) w_state_nxt = w_sbr ? HOLD : IDLE;
      end
      ZREQ: begin
        if (w_bus_free)     w_state_nxt = ZWAIT;
      end
      ZWAIT: begin
        if (!w_ebg)         w_state_nxt = ZREQ;
        else if (w_bus_free) w_state_nxt = OWN;
      end
      OWN: begin
        if (w_abort || w_done || w_cap) w_state_nxt = REL;
      end
      REL: begin
        if (bus.FCS_n)      w_state_nxt = HOLD;
      end
      HOLD: begin
        if (bus.slave_req)  w_state_nxt = SLAVE;
        else if (w_hold_exp) w_state_nxt = w_sbr ? ZREQ : IDLE;
      end
      default:              w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.slave_gnt = 1'b0;
    bus.SBG_n     = 1'b1;
    bus.EBR_n     = 1'b1;
    bus.mybus     = 1'b0;
    unique case (r_state)
      SLAVE: bus.slave_gnt = 1'b1;
      ZREQ:  bus.EBR_n     = 1'b0;
      ZWAIT: bus.EBR_n     = 1'b0;
      OWN: begin
        bus.SBG_n = 1'b0;
        bus.mybus = 1'b1;
      end
      REL:   bus.mybus     = 1'b1;
      default: ;
    endcase
  end

  assign bus.dma_abort = r_dma_abort;

endmodule
